// File: rtl/spi_master_gen.sv
// Full-duplex, MSB-first SPI master with runtime SCK divider and all four CPOL/CPHA modes.
// Define SPI_MASTER_CS_EN to add the automatic chip-select output cs_n and the hold input.
module spi_master_gen #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  div,
  input  logic [DATA_W-1:0] din,
  input  logic              miso,
`ifdef SPI_MASTER_CS_EN
  input  logic              hold,
  output logic              cs_n,
`endif
  output logic              mosi,
  output logic              sck,
  output logic              bsy,
  output logic              done,
  output logic [DATA_W-1:0] dout
);

  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0]    LAST     = EW'(2 * DATA_W - 1);
  localparam logic [EW-1:0]    LAST_M1  = EW'(2 * DATA_W - 2);
  localparam logic [EW-1:0]    EDGE_ONE = EW'(1);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [DIV_W-1:0]    r_cnt;
  logic [DIV_W-1:0]    r_div;
  logic [EW-1:0]       r_edge;
  logic [DATA_W-1:0]   r_shift;
  logic                r_cpha;
  logic                r_sck;
  logic                r_mosi;
  logic                r_bsy;
  logic                r_done;
  logic [DATA_W-1:0]   r_dout;
`ifdef SPI_MASTER_CS_EN
  logic                r_hold;
  logic                r_cs_n;
`endif

  logic w_cnt_zero;
  logic w_accept;
  logic w_edge;
  logic w_lead;
  logic w_last_trail;
  logic w_finish;
  logic w_sample;
  logic w_drive;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nx;
  end

  // r_edge is the 0-based index of the current SHIFT half-period; the edge that
  // closes half-period k is edge k+2, which is leading when k is odd.
  always_comb begin
    w_state_nx   = r_state;
    w_accept     = 1'b0;
    w_edge       = 1'b0;
    w_lead       = 1'b0;
    w_last_trail = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = LEAD;
        end
      end
      LEAD: begin
        if (w_cnt_zero) begin
          w_state_nx = SHIFT;
          w_edge     = 1'b1;
          w_lead     = 1'b1;
        end
      end
      SHIFT: begin
        if (w_cnt_zero) begin
          if (r_edge == LAST) begin
            w_state_nx = TRAIL;
          end else begin
            w_edge       = 1'b1;
            w_lead       = r_edge[0];
            w_last_trail = (r_edge == LAST_M1);
          end
        end
      end
      TRAIL: begin
        if (w_cnt_zero) begin
          w_state_nx = IDLE;
          w_finish   = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // cpha=0 samples on leading edges, cpha=1 on trailing; the other edge drives,
  // except that cpha=0 drives nothing on the final trailing edge.
  assign w_sample = w_edge & (w_lead ^ r_cpha);
  assign w_drive  = w_edge & ~(w_lead ^ r_cpha) & ~(w_last_trail & ~r_cpha);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bsy  <= 1'b0;
      r_done <= 1'b0;
      r_sck  <= 1'b0;
      r_mosi <= 1'b0;
      r_dout <= '0;
`ifdef SPI_MASTER_CS_EN
      r_cs_n <= 1'b1;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_bsy  <= 1'b1;
        r_sck  <= cpol;
        r_mosi <= cpha ? 1'b0 : din[DATA_W-1];
`ifdef SPI_MASTER_CS_EN
        r_cs_n <= 1'b0;
`endif
      end else begin
        if (w_edge)  r_sck  <= ~r_sck;
        if (w_drive) r_mosi <= r_shift[DATA_W-1];
        if (w_finish) begin
          r_dout <= r_shift;
          r_done <= 1'b1;
          r_bsy  <= 1'b0;
          r_mosi <= 1'b0;
`ifdef SPI_MASTER_CS_EN
          r_cs_n <= ~r_hold;
`endif
        end
      end
    end
  end

  // Datapath registers are only meaningful while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift <= din;
      r_cpha  <= cpha;
      r_div   <= div;
      r_cnt   <= div;
`ifdef SPI_MASTER_CS_EN
      r_hold  <= hold;
`endif
    end else if (r_state != IDLE) begin
      r_cnt <= w_cnt_zero ? r_div : (r_cnt - CNT_ONE);
      if (w_sample) r_shift <= {r_shift[DATA_W-2:0], miso};
      if (r_state == LEAD)
        r_edge <= '0;
      else if ((r_state == SHIFT) && w_cnt_zero)
        r_edge <= r_edge + EDGE_ONE;
    end
  end

  assign mosi = r_mosi;
  assign sck  = r_sck;
  assign bsy  = r_bsy;
  assign done = r_done;
  assign dout = r_dout;
`ifdef SPI_MASTER_CS_EN
  assign cs_n = r_cs_n;
`endif

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: 8-bit and 16-bit instances, modes 0/1/2/3,
// back-to-back starts, mid-transfer reset and (with SPI_MASTER_CS_EN) chip-select hold.
module tb_spi_master_gen;

  localparam int LIMIT = 2000;

  logic clk;
  logic rst;

  logic        start8, cpol8, cpha8, hold8;
  logic [7:0]  div8, din8, dout8;
  logic        miso8, mosi8, sck8, bsy8, done8, cs_n8;

  logic        start16, cpol16, cpha16, miso16;
  logic [7:0]  div16;
  logic [15:0] din16, dout16;
  logic        mosi16, sck16, bsy16, done16, cs_n16;

  logic [7:0]  slv8;
  logic [7:0]  cap8;
  logic        loop_sel;
  logic        cs_track;
  int          cs_hi;

  int n_checks;
  int n_errors;

  assign miso8 = loop_sel ? mosi8 : slv8[7];

  spi_master_gen #(.DATA_W(8), .DIV_W(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .cpol  (cpol8),
    .cpha  (cpha8),
    .div   (div8),
    .din   (din8),
    .miso  (miso8),
`ifdef SPI_MASTER_CS_EN
    .hold  (hold8),
    .cs_n  (cs_n8),
`endif
    .mosi  (mosi8),
    .sck   (sck8),
    .bsy   (bsy8),
    .done  (done8),
    .dout  (dout8)
  );

  spi_master_gen #(.DATA_W(16), .DIV_W(8)) u_dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (start16),
    .cpol  (cpol16),
    .cpha  (cpha16),
    .div   (div16),
    .din   (din16),
    .miso  (miso16),
`ifdef SPI_MASTER_CS_EN
    .hold  (1'b0),
    .cs_n  (cs_n16),
`endif
    .mosi  (mosi16),
    .sck   (sck16),
    .bsy   (bsy16),
    .done  (done16),
    .dout  (dout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode-0 slave: presents its MSB and shifts on each falling SCK edge.
  always @(negedge sck8) slv8 = {slv8[6:0], 1'b0};
  always @(posedge sck8) cap8 = {cap8[6:0], mosi8};

  always @(negedge clk) begin
    #1;
    if (cs_track && (cs_n8 === 1'b1)) cs_hi++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic kick(input logic [7:0] d, input logic pol, input logic pha,
                      input logic [7:0] dv, input logic hd);
    din8   = d;
    cpol8  = pol;
    cpha8  = pha;
    div8   = dv;
    hold8  = hd;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_idle(output int busy, output int ndone);
    busy  = 0;
    ndone = 0;
    while ((bsy8 === 1'b1) && (busy < LIMIT)) begin
      busy++;
      if (done8 === 1'b1) ndone++;
      @(negedge clk);
    end
    if (busy >= LIMIT) check_val("bsy8_timeout", 32'(bsy8), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy;
    int nd;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    start8   = 1'b0; cpol8 = 1'b0; cpha8 = 1'b0; hold8 = 1'b0;
    div8     = 8'd0; din8  = 8'd0;
    start16  = 1'b0; cpol16 = 1'b0; cpha16 = 1'b0; miso16 = 1'b1;
    div16    = 8'd0; din16  = 16'd0;
    slv8     = 8'd0; cap8   = 8'd0;
    loop_sel = 1'b0; cs_track = 1'b0; cs_hi = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_bsy",  32'(bsy8),  32'd0);
    check_val("rst_sck",  32'(sck8),  32'd0);
    check_val("rst_mosi", 32'(mosi8), 32'd0);
    check_val("rst_done", 32'(done8), 32'd0);
    check_val("rst_dout", 32'(dout8), 32'd0);
`ifdef SPI_MASTER_CS_EN
    check_val("rst_cs_n", 32'(cs_n8), 32'd1);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Mode 0, div=0, din=0x9F, slave returns 0xEF
    slv8 = 8'hEF;
    cap8 = 8'h00;
    kick(8'h9F, 1'b0, 1'b0, 8'd0, 1'b0);
    check_val("m0_mosi_first", 32'(mosi8), 32'd1);
    check_val("m0_sck_lead",   32'(sck8),  32'd0);
    wait_idle(busy, nd);
    check_val("m0_busy",      32'(busy),  32'd18);
    check_val("m0_no_early",  32'(nd),    32'd0);
    check_val("m0_done",      32'(done8), 32'd1);
    check_val("m0_dout",      32'(dout8), 32'hEF);
    check_val("m0_mosi_bits", 32'(cap8),  32'h9F);
    check_val("m0_mosi_idle", 32'(mosi8), 32'd0);
    @(negedge clk);
    check_val("m0_done_pulse", 32'(done8), 32'd0);

    // Reset during cycle 7 of a mode-2 transfer
    kick(8'hFF, 1'b1, 1'b0, 8'd0, 1'b0);
    repeat (6) @(negedge clk);
    check_val("abort_pre_bsy", 32'(bsy8), 32'd1);
    check_val("abort_pre_sck", 32'(sck8), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_bsy",  32'(bsy8),  32'd0);
    check_val("abort_sck",  32'(sck8),  32'd0);
    check_val("abort_mosi", 32'(mosi8), 32'd0);
    check_val("abort_dout", 32'(dout8), 32'd0);
    rst = 1'b1;
    nd  = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) nd++;
    end
    check_val("abort_no_done", 32'(nd),   32'd0);
    check_val("abort_idle",    32'(bsy8), 32'd0);

    // start held high: back-to-back transfers with a single done cycle between
    din8 = 8'h3C; cpol8 = 1'b0; cpha8 = 1'b0; div8 = 8'd0; start8 = 1'b1;
    @(negedge clk);
    wait_idle(busy, nd);
    check_val("b2b_len1",  32'(busy),  32'd18);
    check_val("b2b_done1", 32'(done8), 32'd1);
    @(negedge clk);
    check_val("b2b_rebusy", 32'(bsy8), 32'd1);
    wait_idle(busy, nd);
    check_val("b2b_len2",  32'(busy),  32'd18);
    check_val("b2b_done2", 32'(done8), 32'd1);
    start8 = 1'b0;
    @(negedge clk);
    check_val("b2b_stop", 32'(bsy8), 32'd0);

    // Mode 3, div=3, din=0xA5, miso looped to mosi
    loop_sel = 1'b1;
    kick(8'hA5, 1'b1, 1'b1, 8'd3, 1'b0);
    check_val("m3_sck_idle1", 32'(sck8),  32'd1);
    check_val("m3_mosi_lead", 32'(mosi8), 32'd0);
    wait_idle(busy, nd);
    check_val("m3_busy",    32'(busy),  32'd72);
    check_val("m3_no_early", 32'(nd),   32'd0);
    check_val("m3_done",    32'(done8), 32'd1);
    check_val("m3_dout",    32'(dout8), 32'hA5);
    @(negedge clk);
    check_val("m3_sck_rest", 32'(sck8),  32'd1);
    check_val("m3_done_pulse", 32'(done8), 32'd0);

`ifdef SPI_MASTER_CS_EN
    // Two words with hold=1 then hold=0
    check_val("cs_idle_high", 32'(cs_n8), 32'd1);
    kick(8'h03, 1'b0, 1'b0, 8'd0, 1'b1);
    check_val("cs_fall", 32'(cs_n8), 32'd0);
    cs_track = 1'b1;
    wait_idle(busy, nd);
    check_val("cs_held_done1", 32'(cs_n8), 32'd0);
    kick(8'h05, 1'b0, 1'b0, 8'd0, 1'b0);
    wait_idle(busy, nd);
    cs_track = 1'b0;
    check_val("cs_cont_low", 32'(cs_hi), 32'd0);
    check_val("cs_done2",    32'(done8), 32'd1);
    check_val("cs_rise",     32'(cs_n8), 32'd1);
    @(negedge clk);
`endif

    // DATA_W=16, mode 1, div=0, din=0x1234, miso tied 1
    din16 = 16'h1234; cpol16 = 1'b0; cpha16 = 1'b1; div16 = 8'd0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    busy = 0;
    while ((bsy16 === 1'b1) && (busy < LIMIT)) begin
      busy++;
      @(negedge clk);
    end
    if (busy >= LIMIT) check_val("bsy16_timeout", 32'(bsy16), 32'd0);
    check_val("w16_busy", 32'(busy),   32'd34);
    check_val("w16_done", 32'(done16), 32'd1);
    check_val("w16_dout", 32'(dout16), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
